// File: rtl/tpa_reg_arbiter.sv
// Two-master register file arbiter: ports A and B share one 2**AW x DW array via an IDLE/ACC/DONE FSM.
// Optional macro TPA_ARB_FIXED_PRIO_EN: A always wins ties; default build arbitrates round-robin.
module tpa_reg_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_cmd,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rdy,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_cmd,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rdy,
  output logic [DW-1:0] b_rdata,
  output logic          busy
);
  localparam int DEPTH = 2**AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          owner;      // 0 = port A, 1 = port B
  logic          cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          grant_b;
  logic [DW-1:0] mem [DEPTH];

`ifdef TPA_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_b = b_req & ~a_req;
  end
`else
  logic last_owner;

  // On a tie B wins only when A was the most recent owner.
  always_comb begin
    grant_b = b_req & (~a_req | ~last_owner);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner <= 1'b1;
    end else if (state == ACC) begin
      last_owner <= owner;
    end
  end
`endif

  // Storage is cleared on reset so contents are defined even if an access was cut short.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == ACC && cmd_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      a_rdy   <= 1'b0;
      b_rdy   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            owner   <= grant_b;
            cmd_q   <= grant_b ? b_cmd   : a_cmd;
            addr_q  <= grant_b ? b_addr  : a_addr;
            wdata_q <= grant_b ? b_wdata : a_wdata;
            state   <= ACC;
            busy    <= 1'b1;
          end
        end
        ACC: begin
          if (owner) begin
            b_rdy <= 1'b1;
            if (!cmd_q) begin
              b_rdata <= mem[addr_q];
            end
          end else begin
            a_rdy <= 1'b1;
            if (!cmd_q) begin
              a_rdata <= mem[addr_q];
            end
          end
          state <= DONE;
        end
        DONE: begin
          // Requests are ignored here; the master drops req while rdy is high.
          a_rdy <= 1'b0;
          b_rdy <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          a_rdy <= 1'b0;
          b_rdy <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tpa_reg_arbiter.sv
// Self-checking bench for tpa_reg_arbiter: per-port transaction queues checked cycle by cycle
// against a transaction-level model (array contents, arbitration rule, fixed 3-cycle access timing).
`timescale 1ns/1ps
module tb_tpa_reg_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req = 1'b0, a_cmd = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_rdy;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0, b_cmd = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_rdy;
  logic [DW-1:0] b_rdata;
  logic          busy;

  always #5 clk = ~clk;

  tpa_reg_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_cmd(a_cmd), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdy(a_rdy), .a_rdata(a_rdata),
    .b_req(b_req), .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdy(b_rdy), .b_rdata(b_rdata),
    .busy(busy)
  );

  typedef struct {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gap;
  } op_t;

  op_t           qa[$];
  op_t           qb[$];
  logic [DW-1:0] mdl_mem [2**AW];
  logic [DW-1:0] mdl_rd [2];
  int            mdl_last;
  int            checks = 0;
  int            failures = 0;

  function automatic op_t mk(input logic cmd, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int gap);
    op_t o;
    o.cmd = cmd; o.addr = addr; o.wdata = wdata; o.gap = gap;
    return o;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2**AW; i++) mdl_mem[i] = '0;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    mdl_last = 1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  // Drives both queues as independent masters and checks every cycle against the model.
  task automatic run_traffic(input string tag, input int budget);
    int k = 0, free_k = 0, due_k = -10, exp_port = 0, cnt_a = 0, cnt_b = 0;
    logic exp_cmd = 1'b0;
    logic [DW-1:0] exp_rd = '0;
    logic ea, eb, eby, done_a, done_b, win_b;
    op_t o;
    forever begin
      @(negedge clk);
      k++;
      ea  = (due_k == k) && (exp_port == 0);
      eb  = (due_k == k) && (exp_port == 1);
      eby = (k == due_k - 1) || (k == due_k);
      if (due_k == k && !exp_cmd) mdl_rd[exp_port] = exp_rd;
      checks++;
      if ({a_rdy, b_rdy, busy} !== {ea, eb, eby}) begin
        failures++;
        $display("FAIL %s handshake cycle %0d: a_rdy/b_rdy/busy got %b%b%b expected %b%b%b",
                 tag, k, a_rdy, b_rdy, busy, ea, eb, eby);
      end
      checks++;
      if (a_rdata !== mdl_rd[0] || b_rdata !== mdl_rd[1]) begin
        failures++;
        $display("FAIL %s rdata cycle %0d: a_rdata/b_rdata got %h/%h expected %h/%h",
                 tag, k, a_rdata, b_rdata, mdl_rd[0], mdl_rd[1]);
      end
      done_a = 1'b0;
      done_b = 1'b0;
      if (due_k == k) begin
        $display("%s txn: port %s %s addr=%h data=%h", tag, exp_port ? "B" : "A",
                 exp_cmd ? "WR" : "RD", exp_port ? qb[0].addr : qa[0].addr,
                 exp_cmd ? (exp_port ? qb[0].wdata : qa[0].wdata) : exp_rd);
        if (exp_port == 0) begin a_req = 1'b0; void'(qa.pop_front()); cnt_a = 0; done_a = 1'b1; end
        else               begin b_req = 1'b0; void'(qb.pop_front()); cnt_b = 0; done_b = 1'b1; end
      end
      if (!a_req && !done_a && qa.size() > 0) begin
        if (cnt_a >= qa[0].gap) begin
          a_req = 1'b1; a_cmd = qa[0].cmd; a_addr = qa[0].addr; a_wdata = qa[0].wdata; cnt_a = 0;
        end else cnt_a++;
      end
      if (!b_req && !done_b && qb.size() > 0) begin
        if (cnt_b >= qb[0].gap) begin
          b_req = 1'b1; b_cmd = qb[0].cmd; b_addr = qb[0].addr; b_wdata = qb[0].wdata; cnt_b = 0;
        end else cnt_b++;
      end
      // The arbiter is free again three cycles after a grant.
      if (k >= free_k && (a_req || b_req)) begin
        if (a_req && b_req) begin
`ifdef TPA_ARB_FIXED_PRIO_EN
          win_b = 1'b0;
`else
          win_b = (mdl_last == 0);
`endif
        end else begin
          win_b = b_req;
        end
        o = win_b ? qb[0] : qa[0];
        if (o.cmd) mdl_mem[o.addr] = o.wdata;
        else exp_rd = mdl_mem[o.addr];
        exp_cmd  = o.cmd;
        exp_port = win_b ? 1 : 0;
        mdl_last = exp_port;
        due_k    = k + 2;
        free_k   = k + 3;
      end
      if (qa.size() == 0 && qb.size() == 0 && k > due_k) break;
      if (k >= budget) begin
        checks++;
        failures++;
        $display("FAIL %s timeout: %0d cycles elapsed, %0d/%0d ops left, limit %0d",
                 tag, k, qa.size(), qb.size(), budget);
        a_req = 1'b0;
        b_req = 1'b0;
        qa.delete();
        qb.delete();
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_rdy, b_rdy, busy} !== 3'b000 || a_rdata !== '0 || b_rdata !== '0) begin
      failures++;
      $display("FAIL reset_hold: rdy/rdy/busy=%b%b%b rdata=%h/%h expected 000 0000/0000",
               a_rdy, b_rdy, busy, a_rdata, b_rdata);
    end
    reset_n = 1'b1;
    model_clear();
    @(negedge clk);
    checks++;
    if ({a_rdy, b_rdy, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release: rdy/rdy/busy=%b%b%b expected 000", a_rdy, b_rdy, busy);
    end
  endtask

  task automatic test_write_read();
    qa.push_back(mk(1'b1, 8'h10, 16'hBEEF, 0));
    qa.push_back(mk(1'b0, 8'h10, 16'h0000, 0));
    run_traffic("write_read", 100);
  endtask

  task automatic test_tie();
    do_reset();
    qa.push_back(mk(1'b0, 8'h01, 16'h0000, 0));
    qb.push_back(mk(1'b0, 8'h02, 16'h0000, 0));
    run_traffic("tie", 100);
  endtask

  task automatic test_same_addr();
    qb.push_back(mk(1'b1, 8'h21, 16'h7777, 0));
    run_traffic("same_addr_pre", 100);
    qa.push_back(mk(1'b1, 8'h20, 16'h1111, 0));
    qb.push_back(mk(1'b1, 8'h20, 16'h2222, 0));
    qa.push_back(mk(1'b0, 8'h20, 16'h0000, 3));
    run_traffic("same_addr", 100);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) qa.push_back(mk(1'b0, 8'h20 + 8'(i), 16'h0000, 0));
    for (int i = 0; i < 3; i++) qb.push_back(mk(1'b0, 8'h10, 16'h0000, 0));
    run_traffic("back_to_back", 200);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_cmd = 1'b1; a_addr = 8'h30; a_wdata = 16'h5A5A; a_req = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_acc: busy got %b expected 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_rdy, b_rdy, busy} !== 3'b000 || a_rdata !== '0 || b_rdata !== '0) begin
      failures++;
      $display("FAIL reset_mid_async: rdy/rdy/busy=%b%b%b rdata=%h/%h expected 000 0000/0000",
               a_rdy, b_rdy, busy, a_rdata, b_rdata);
    end
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    @(negedge clk);
    qa.push_back(mk(1'b0, 8'h30, 16'h0000, 0));
    qa.push_back(mk(1'b0, 8'h20, 16'h0000, 0));
    qb.push_back(mk(1'b0, 8'h10, 16'h0000, 1));
    run_traffic("reset_mid", 100);
  endtask

  task automatic test_untouched_hold();
    qa.push_back(mk(1'b1, 8'h40, 16'h1234, 0));
    qa.push_back(mk(1'b0, 8'h40, 16'h0000, 0));
    qa.push_back(mk(1'b0, 8'hFF, 16'h0000, 0));
    qb.push_back(mk(1'b0, 8'h40, 16'h0000, 5));
    run_traffic("untouched", 100);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (a_rdata !== 16'h0000 || b_rdata !== 16'h1234 || a_rdy !== 1'b0 || b_rdy !== 1'b0) begin
        failures++;
        $display("FAIL untouched_hold: a_rdata/b_rdata=%h/%h rdy=%b%b expected 0000/1234 rdy=00",
                 a_rdata, b_rdata, a_rdy, b_rdy);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] ad;
    for (int i = 0; i < 40; i++) begin
      ad = ($urandom_range(0, 3) == 0) ? AW'($urandom) : (8'h50 + AW'($urandom_range(0, 7)));
      qa.push_back(mk(1'($urandom), ad, DW'($urandom), $urandom_range(0, 3)));
      ad = ($urandom_range(0, 3) == 0) ? AW'($urandom) : (8'h50 + AW'($urandom_range(0, 7)));
      qb.push_back(mk(1'($urandom), ad, DW'($urandom), $urandom_range(0, 3)));
    end
    run_traffic("random", 2000);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_same_addr();
    test_back_to_back();
    test_reset_mid();
    test_untouched_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
